nibble_link_mem_ctrl: RTL and testbench



---
 rtl/nibble_link_pkg.sv | 25 ++
 rtl/nibble_link_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_nibble_link_mem_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/nibble_link_pkg.sv
// Shared types for the nibble-link memory controller and its verification memory model.
package nibble_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WCOLLECT,
    WMEM,
    RMEM,
    RCAP,
    RSEND,
    RCOMMIT
  } nlc_state_e;

  localparam int NibblesPerWord = 8;
  localparam int LinkAddrWidth  = 8;
  localparam int LinkDataWidth  = 32;

  typedef struct packed {
    logic [LinkAddrWidth-1:0]   addr;
    logic [LinkDataWidth-1:0]   wdata;
    logic [LinkDataWidth/8-1:0] be;
    logic                       we;
  } nl_mem_req_t;

endpackage

// File: rtl/nibble_link_mem_ctrl.sv
// Far-side controller of the nibble link: collects nibble-serial writes into SRAM words
// and streams read words back MSB-nibble first, followed by a commit beat.
module nibble_link_mem_ctrl
  import nibble_link_pkg::*;
#(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             req_nibble,
  input  logic [AddrWidth-1:0]   req_addr,
  input  logic                   req_write,
  input  logic                   req_strb,
  input  logic                   req_valid,
  output logic                   req_ready,
  output logic [3:0]             rsp_nibble,
  output logic                   rsp_valid,
  output logic                   rsp_last,
  input  logic                   rsp_ready,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AddrWidth-1:0]   mem_addr,
  output logic [DataWidth-1:0]   mem_wdata,
  output logic [DataWidth/8-1:0] mem_be,
  input  logic [DataWidth-1:0]   mem_rdata,
  output logic                   proto_err
);

  localparam int NumNibbles = DataWidth / 4;
  localparam int NumBytes   = DataWidth / 8;
  localparam int CntWidth   = $clog2(NumNibbles);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumNibbles - 1);

  nlc_state_e            state_q, state_d;
  logic [CntWidth-1:0]   cnt_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [DataWidth-1:0]  wdata_q;
  logic [NumNibbles-1:0] nstrb_q;
  logic [DataWidth-1:0]  shift_q;
  logic                  proto_err_q;
  logic [NumBytes-1:0]   be;
  logic                  bad_beat;

  // A write beat must keep the write flag and the address it started with.
  assign bad_beat = req_valid && (!req_write || (req_addr != addr_q));

  always_comb begin
    for (int i = 0; i < NumBytes; i++) begin
      be[i] = nstrb_q[2*i] & nstrb_q[2*i+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_last   = 1'b0;
    rsp_nibble = 4'h0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = req_write ? WCOLLECT : RMEM;
        end
      end
      WCOLLECT: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad_beat) begin
            state_d = IDLE;
          end else if (cnt_q == LastCnt) begin
            state_d = WMEM;
          end
        end
      end
      WMEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        state_d = IDLE;
      end
      RMEM: begin
        mem_req = 1'b1;
        state_d = RCAP;
      end
      RCAP: begin
        state_d = RSEND;
      end
      RSEND: begin
        rsp_valid  = 1'b1;
        rsp_nibble = shift_q[DataWidth-1 -: 4];
        rsp_last   = (cnt_q == LastCnt);
        if (rsp_ready && (cnt_q == LastCnt)) begin
          state_d = RCOMMIT;
        end
      end
      RCOMMIT: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side fields are zeroed outside an access so idle outputs match reset.
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = (state_q == WMEM) ? wdata_q : '0;
  assign mem_be    = (state_q == WMEM) ? be : '0;
  assign proto_err = proto_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      nstrb_q     <= '0;
      shift_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            if (req_write) begin
              wdata_q <= DataWidth'(req_nibble);
              nstrb_q <= NumNibbles'(req_strb);
              cnt_q   <= CntWidth'(1);
            end else begin
              cnt_q <= '0;
            end
          end
        end
        WCOLLECT: begin
          if (req_valid) begin
            if (bad_beat) begin
              proto_err_q <= 1'b1;
              cnt_q       <= '0;
            end else begin
              wdata_q[{cnt_q, 2'b00} +: 4] <= req_nibble;
              nstrb_q[cnt_q]               <= req_strb;
              cnt_q <= (cnt_q == LastCnt) ? '0 : cnt_q + CntWidth'(1);
            end
          end
        end
        RCAP: begin
          shift_q <= mem_rdata;
          cnt_q   <= '0;
        end
        RSEND: begin
          if (rsp_ready) begin
            shift_q <= shift_q << 4;
            cnt_q   <= (cnt_q == LastCnt) ? '0 : cnt_q + CntWidth'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_link_mem_ctrl.sv
// Scoreboard bench for nibble_link_mem_ctrl: stimulus pushes expected SRAM accesses and
// response beats into queues, a negedge monitor pops and compares them.
module tb_nibble_link_mem_ctrl;
  import nibble_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_nibble = '0;
  logic [7:0]  req_addr = '0;
  logic        req_write = 1'b0;
  logic        req_strb = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  rsp_nibble;
  logic        rsp_valid;
  logic        rsp_last;
  logic        rsp_ready = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        proto_err;

  typedef struct packed {
    logic [3:0] nib;
    logic       last;
    logic       commit;
  } rsp_exp_t;

  nl_mem_req_t memQ[$];
  rsp_exp_t    rspQ[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mem [256] = '{5: 32'h12345678, default: 32'h0};

  always #5 clk = ~clk;

  nibble_link_mem_ctrl #(.AddrWidth(8), .DataWidth(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_nibble(req_nibble), .req_addr(req_addr), .req_write(req_write),
    .req_strb(req_strb), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_nibble(rsp_nibble), .rsp_valid(rsp_valid), .rsp_last(rsp_last),
    .rsp_ready(rsp_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // SRAM model with one-cycle read latency and byte-enabled writes.
  always @(posedge clk) begin
    if (mem_req && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (mem_req && !mem_we) mem_rdata <= mem[mem_addr];
  end

  // Monitor: SRAM accesses and response beats are compared against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        if (memQ.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_mem_req: got addr 0x%0h we %0b, expected none", mem_addr, mem_we);
        end else begin
          nl_mem_req_t e;
          e = memQ.pop_front();
          checkOutput("mem_we", mem_we, e.we);
          checkOutput("mem_addr", mem_addr, e.addr);
          if (e.we) begin
            checkOutput("mem_wdata", mem_wdata, e.wdata);
            checkOutput("mem_be", mem_be, e.be);
          end
        end
      end
      if (rsp_valid) begin
        checkOutput("req_ready_busy", req_ready, 0);
        if (rspQ.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_rsp: got nibble 0x%0h last %0b, expected none", rsp_nibble, rsp_last);
        end else begin
          rsp_exp_t r;
          r = rspQ[0];
          checkOutput(r.commit ? "commit_nibble" : "rsp_nibble", rsp_nibble, r.nib);
          checkOutput(r.commit ? "commit_last" : "rsp_last", rsp_last, r.last);
          if (r.commit || rsp_ready) void'(rspQ.pop_front());
        end
      end
    end
  end

  task automatic sendBeat(input logic [3:0] nib, input logic [7:0] addr, input logic wr,
                          input logic strb);
    bit done = 0;
    req_nibble = nib; req_addr = addr; req_write = wr; req_strb = strb; req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        done = 1;
        break;
      end
    end
    req_valid = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("[TB] FAIL beat_timeout: got no req_ready, expected handshake");
    end
  endtask

  task automatic writeWord(input logic [7:0] addr, input logic [31:0] data,
                           input logic [7:0] strb, input logic [3:0] exp_be);
    memQ.push_back('{addr: addr, wdata: data, be: exp_be, we: 1'b1});
    for (int k = 0; k < NibblesPerWord; k++) sendBeat(data[4*k +: 4], addr, 1'b1, strb[k]);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic readWord(input logic [7:0] addr, input logic [31:0] exp_data,
                          input logic [3:0] pattern);
    bit done = 0;
    memQ.push_back('{addr: addr, wdata: 32'h0, be: 4'h0, we: 1'b0});
    for (int k = 0; k < NibblesPerWord; k++)
      rspQ.push_back('{nib: exp_data[31-4*k -: 4], last: (k == NibblesPerWord-1), commit: 1'b0});
    rspQ.push_back('{nib: 4'h0, last: 1'b0, commit: 1'b1});
    rsp_ready = pattern[3];
    sendBeat(4'h0, addr, 1'b0, 1'b0);
    checkOutput("rmem_req", mem_req, 1);
    for (int c = 0; c < 100; c++) begin
      rsp_ready = pattern[3 - (c % 4)];
      @(posedge clk); #1;
      if (rspQ.size() == 0) begin
        done = 1;
        break;
      end
    end
    rsp_ready = 1'b1;
    if (!done) begin
      tests++; fails++;
      $display("[TB] FAIL read_timeout: got %0d beats pending, expected 0", rspQ.size());
      rspQ.delete();
    end
    checkOutput("read_idle_ready", req_ready, 1);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_mem_be", mem_be, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_last", rsp_last, 0);
    checkOutput("rst_rsp_nibble", rsp_nibble, 0);
    checkOutput("rst_proto_err", proto_err, 0);
  endtask

  initial begin
    #1;
    checkResetOutputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    writeWord(8'h12, 32'hDEADBEEF, 8'hFF, 4'b1111);
    readWord(8'h05, 32'h12345678, 4'b1111);
    writeWord(8'h30, 32'hCAFEF00D, 8'h0F, 4'b0011);
    writeWord(8'h31, 32'hA5A5A5A5, 8'b1111_1101, 4'b1110);
    readWord(8'h12, 32'hDEADBEEF, 4'b1001);

    // Address changes on nibble 3: the write must be dropped and the error latched.
    for (int k = 0; k < 3; k++) sendBeat(4'(k), 8'h20, 1'b1, 1'b1);
    sendBeat(4'h3, 8'h21, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("proto_err_set", proto_err, 1);
    checkOutput("proto_idle_ready", req_ready, 1);
    readWord(8'h30, 32'h0000F00D, 4'b1111);
    readWord(8'h31, 32'hA5A5A500, 4'b1111);

    // Reset in the middle of a write: nothing reaches the SRAM.
    for (int k = 0; k < 6; k++) sendBeat(4'hF, 8'h40, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    writeWord(8'h40, 32'h01234567, 8'hFF, 4'b1111);
    readWord(8'h40, 32'h01234567, 4'b1111);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("mem_queue_drained", memQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
